// File: rtl/mul_pkg.sv
// Shared constants and helpers for the nibble-step multiplier sequencer.
package mul_pkg;

  // Step-state encodings understood by the combinational step unit
  localparam logic [2:0] ST_START = 3'b000;
  localparam logic [2:0] ST_A0    = 3'b001;
  localparam logic [2:0] ST_BC    = 3'b010;
  localparam logic [2:0] ST_B0    = 3'b011;
  localparam logic [2:0] ST_AD    = 3'b100;
  localparam logic [2:0] ST_HOLD  = 3'b110;
  localparam logic [2:0] ST_DONE  = 3'b111;

  // Handshake phases of the sequencer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } phaseT;

  // Nibble layout the step unit expects for its operand bus
  function automatic logic [15:0] pack_pcl1(input logic [7:0] opA, input logic [7:0] opB);
    return {opA[7:4], opA[3:0], opB[7:4], opB[3:0]};
  endfunction

endpackage

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the nibble-step multiplier: owns the step-state register and
// the accumulator, walks the step unit one state per cycle, and returns the
// low product byte (or a watchdog error) over a valid/ready handshake.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int MAX_STEPS = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_err,
  output logic [15:0] stp_pcl1,
  output logic [7:0]  stp_pcl2,
  output logic [2:0]  stp_state,
  input  logic [2:0]  stp_next,
  input  logic [7:0]  stp_n1,
  input  logic [7:0]  stp_n2,
  input  logic        stp_done
);

  phaseT      phase;
  logic [7:0] opA;
  logic [7:0] opB;
  logic [7:0] acc;
  logic [3:0] stepCnt;
  logic       accept;
  logic       lastStep;

  // A new pair may be taken while idle, or in the same edge that hands the
  // held result over.
  assign req_ready = (phase == IDLE) || ((phase == HOLD) && res_ready);
  assign accept    = req_valid && req_ready;

  // The step executing now is the MAX_STEPS-th one since the operands were
  // accepted; if it is not the final state, the chain is abandoned.
  assign lastStep  = (({1'b0, stepCnt} + 5'd1) == 5'(MAX_STEPS));

  // Step-unit inputs are driven from registers only.
  assign stp_pcl1  = pack_pcl1(opA, opB);
  assign stp_pcl2  = acc;

  // Phase sequencing, step-state walk, accumulator and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= IDLE;
      opA       <= '0;
      opB       <= '0;
      acc       <= '0;
      stepCnt   <= '0;
      stp_state <= ST_DONE;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
    end else begin
      case (phase)
        IDLE: ;
        RUN: begin
          stp_state <= stp_next;
          acc       <= stp_n2;
          stepCnt   <= stepCnt + 4'd1;
          if (stp_done) begin
            res_data  <= stp_n1;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            phase     <= HOLD;
            stp_state <= ST_DONE;
          end else if (lastStep) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            phase     <= HOLD;
            stp_state <= ST_DONE;
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            phase     <= IDLE;
          end
        end
        default: phase <= IDLE;
      endcase

      // Accept only happens in IDLE or HOLD, so this overrides the HOLD exit.
      if (accept) begin
        opA       <= op_a;
        opB       <= op_b;
        acc       <= '0;
        stepCnt   <= '0;
        stp_state <= ST_START;
        phase     <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with a behavioural nibble-step unit.
module tb_mul_seq_ctrl;

  localparam int MAX_STEPS = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic        resValid;
  logic        resReady;
  logic [7:0]  resData;
  logic        resErr;
  logic [15:0] stpPcl1;
  logic [7:0]  stpPcl2;
  logic [2:0]  stpState;
  logic [2:0]  stpNext;
  logic [7:0]  stpN1;
  logic [7:0]  stpN2;
  logic        stpDone;
  logic        neverDone;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } expT;
  expT sbQ[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expData;
    int         expLat;
  } vecT;

  mul_seq_ctrl #(.MAX_STEPS(MAX_STEPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .op_a      (opA),
    .op_b      (opB),
    .res_valid (resValid),
    .res_ready (resReady),
    .res_data  (resData),
    .res_err   (resErr),
    .stp_pcl1  (stpPcl1),
    .stp_pcl2  (stpPcl2),
    .stp_state (stpState),
    .stp_next  (stpNext),
    .stp_n1    (stpN1),
    .stp_n2    (stpN2),
    .stp_done  (stpDone)
  );

  always #5 clk = ~clk;

  // Behavioural step unit: low-byte product built from nibble partial products
  logic [3:0] aHi, aLo, bHi, bLo;
  logic [7:0] pLL, pHL, pLH;
  always_comb begin
    aHi = stpPcl1[15:12];
    aLo = stpPcl1[11:8];
    bHi = stpPcl1[7:4];
    bLo = stpPcl1[3:0];
    pLL = {4'b0, aLo} * {4'b0, bLo};
    pHL = {4'b0, aHi} * {4'b0, bLo};
    pLH = {4'b0, aLo} * {4'b0, bHi};
    stpNext = 3'b111;
    stpN2   = stpPcl2;
    stpN1   = stpPcl2;
    stpDone = 1'b0;
    case (stpState)
      3'b000: begin stpN2 = pLL; stpNext = 3'b010; end
      3'b010: begin
        if (aHi == 4'd0) begin stpN2 = stpPcl2 + (pLH << 4); stpNext = 3'b011; end
        else begin stpN2 = stpPcl2 + (pHL << 4); stpNext = 3'b100; end
      end
      3'b011: stpNext = 3'b111;
      3'b100: begin
        if (bHi == 4'd0) stpNext = 3'b111;
        else begin stpN2 = stpPcl2 + (pLH << 4); stpNext = 3'b110; end
      end
      3'b110: stpNext = 3'b111;
      3'b111: stpDone = !neverDone;
      default: stpNext = 3'b111;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Wait for the result of the op accepted one edge before the current negedge
  task automatic waitResult(input int expLat);
    int lat;
    expT e;
    lat = 1;
    while (!resValid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!resValid) begin
      chk("result_timeout", 32'(lat), 32'(expLat));
      if (sbQ.size() > 0) void'(sbQ.pop_front());
    end else begin
      chk("latency", 32'(lat), 32'(expLat));
      if (sbQ.size() == 0) begin
        chk("sb_unexpected_result", 32'(resData), 32'hFFFF);
      end else begin
        e = sbQ.pop_front();
        chk("res_data", 32'(resData), 32'(e.data));
        chk("res_err", 32'(resErr), 32'(e.err));
      end
    end
  endtask

  task automatic releaseResult();
    resReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resReady = 1'b0;
    chk("res_valid_drop", 32'(resValid), 32'd0);
  endtask

  task automatic doOp(input logic [7:0] a, input logic [7:0] b, input int expLat,
                      input logic [7:0] expData, input logic expErr);
    expT e;
    @(negedge clk);
    opA = a;
    opB = b;
    reqValid = 1'b1;
    chk("req_ready_idle", 32'(reqReady), 32'd1);
    e.data = expData;
    e.err  = expErr;
    sbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    chk("stp_pcl1", 32'(stpPcl1), 32'({a, b}));
    chk("req_ready_run", 32'(reqReady), 32'd0);
    waitResult(expLat);
    releaseResult();
  endtask

  vecT vecs[7];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    expT e;
    vecs[0] = '{8'h23, 8'h45, 8'h6F, 6};
    vecs[1] = '{8'h03, 8'h45, 8'hCF, 5};
    vecs[2] = '{8'h23, 8'h05, 8'hAF, 5};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 5};
    vecs[4] = '{8'hFF, 8'hFF, 8'h01, 6};
    vecs[5] = '{8'h10, 8'h10, 8'h00, 6};
    vecs[6] = '{8'h0F, 8'h0F, 8'hE1, 5};

    reset = 1'b1; reqValid = 1'b0; resReady = 1'b0;
    opA = 8'h00; opB = 8'h00; neverDone = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(reqReady), 32'd1);
    chk("rst_res_valid", 32'(resValid), 32'd0);
    chk("rst_res_data", 32'(resData), 32'd0);
    chk("rst_res_err", 32'(resErr), 32'd0);
    chk("rst_stp_state", 32'(stpState), 32'd7);
    chk("rst_stp_pcl2", 32'(stpPcl2), 32'd0);
    chk("rst_stp_pcl1", 32'(stpPcl1), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++)
      doOp(vecs[i].a, vecs[i].b, vecs[i].expLat, vecs[i].expData, 1'b0);

    // Back-pressure on the result while a new request waits
    @(negedge clk);
    opA = 8'h23; opB = 8'h45; reqValid = 1'b1;
    e.data = 8'h6F; e.err = 1'b0; sbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    opA = 8'h11; opB = 8'h22;
    waitResult(6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_res_data", 32'(resData), 32'h6F);
      chk("hold_res_valid", 32'(resValid), 32'd1);
      chk("hold_req_ready", 32'(reqReady), 32'd0);
    end
    resReady = 1'b1;
    #1;
    chk("handoff_req_ready", 32'(reqReady), 32'd1);
    e.data = 8'h42; e.err = 1'b0; sbQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    resReady = 1'b0; reqValid = 1'b0;
    chk("handoff_res_valid", 32'(resValid), 32'd0);
    chk("handoff_pcl1", 32'(stpPcl1), 32'h1122);
    waitResult(6);
    releaseResult();

    // Step unit that never finishes
    neverDone = 1'b1;
    doOp(8'h23, 8'h45, MAX_STEPS + 1, 8'h00, 1'b1);
    neverDone = 1'b0;
    doOp(8'h23, 8'h05, 5, 8'hAF, 1'b0);

    // Reset in the middle of a run
    @(negedge clk);
    opA = 8'h23; opB = 8'h45; reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", 32'(reqReady), 32'd1);
    chk("abort_stp_state", 32'(stpState), 32'd7);
    chk("abort_stp_pcl2", 32'(stpPcl2), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_result", 32'(resValid), 32'd0);
    end
    doOp(8'hFF, 8'hFF, 6, 8'h01, 1'b0);

    chk("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
